// File: rtl/keypad_emulator.sv
// keypad_emulator: replays queued key commands onto a scanned key matrix.
// Rows are driven combinationally from the scanner's column strobes.
module keypad_emulator #(
    parameter int COLS       = 3,
    parameter int ROWS       = 3,
    parameter int HOLD_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 8,
    localparam int KEY_W     = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [KEY_W-1:0]  cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [COLS-1:0]   column,
    output logic [ROWS-1:0]   row,
    output logic              press_active,
    output logic              key_done,
    output logic              cmd_err,
    output logic              busy
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int GW   = $clog2(GAP_CYCLES + 1);
    localparam logic [KEY_W:0] NKEYS = (KEY_W + 1)'(ROWS * COLS);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        RELEASE
    } state_t;

    state_t state, state_n;

    logic [KEY_W-1:0]  fifo_key  [FIFO_DEPTH];
    logic [HOLD_W-1:0] fifo_hold [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CNTW-1:0]   count;

    logic              full, key_ok, push, pop;
    logic [HOLD_W-1:0] cnt, cnt_n;
    logic [GW-1:0]     gap, gap_n;
    logic [KEY_W-1:0]  krow, kcol;
    logic              done_n;
    logic              col_hit;

    assign full      = (count == CNTW'(FIFO_DEPTH));
    assign cmd_ready = rst_n && !full;
    assign key_ok    = ({1'b0, cmd_key} < NKEYS);
    assign push      = cmd_valid && cmd_ready && key_ok;

    // Command FIFO storage, pointers, occupancy and range-error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= cmd_valid && cmd_ready && !key_ok;
            if (push) begin
                fifo_key[wr_ptr]  <= cmd_key;
                fifo_hold[wr_ptr] <= cmd_hold;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + CNTW'(1);
            end else if (pop && !push) begin
                count <= count - CNTW'(1);
            end
        end
    end

    // Replay FSM registers plus the key decoded at pop time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            gap      <= '0;
            krow     <= '0;
            kcol     <= '0;
            key_done <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            gap      <= gap_n;
            key_done <= done_n;
            if (pop) begin
                krow <= KEY_W'(fifo_key[rd_ptr] / COLS);
                kcol <= KEY_W'(fifo_key[rd_ptr] % COLS);
            end
        end
    end

    // Next-state logic: pop, press for the hold count, then a forced gap.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gap_n   = gap;
        pop     = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_n = PRESS;
                    cnt_n   = (fifo_hold[rd_ptr] == '0) ? HOLD_W'(1)
                                                        : fifo_hold[rd_ptr];
                end
            end
            PRESS: begin
                cnt_n = cnt - HOLD_W'(1);
                if (cnt <= HOLD_W'(1)) begin
                    state_n = RELEASE;
                    done_n  = 1'b1;
                    gap_n   = GW'(GAP_CYCLES);
                end
            end
            RELEASE: begin
                gap_n = gap - GW'(1);
                if (gap <= GW'(1)) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign press_active = (state == PRESS);
    assign busy         = (count != '0) || (state != IDLE);
    assign col_hit      = |(column & (COLS'(1) << kcol));

    // Row returns follow the column strobes with no register in the path.
    always_comb begin
        row = '0;
        for (int r = 0; r < ROWS; r++) begin
            row[r] = press_active && (krow == KEY_W'(r)) && col_hit;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed tests for keypad_emulator.
// Inputs change on the falling edge; outputs are checked there too.
module tb_keypad_emulator;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_key;
    logic [15:0] cmd_hold;
    logic [2:0]  column;
    logic [2:0]  row;
    logic        press_active;
    logic        key_done;
    logic        cmd_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    keypad_emulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_key      (cmd_key),
        .cmd_hold     (cmd_hold),
        .column       (column),
        .row          (row),
        .press_active (press_active),
        .key_done     (key_done),
        .cmd_err      (cmd_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int decode(input logic [2:0] rw, input logic [2:0] cl);
        int k;
        k = -1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (rw[r] && cl[c]) k = r * 3 + c;
        return k;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic push(input int k, input int h);
        int t;
        t = 0;
        cmd_valid = 1'b1;
        cmd_key   = 4'(k);
        cmd_hold  = 16'(h);
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (t >= 100) begin
            bad++;
            $display("FAIL push_timeout key=%0d got ready=0 want 1", k);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic scan_key(output int k);
        k = -1;
        for (int c = 0; c < 3; c++) begin
            column = 3'(1 << c);
            #1;
            if (row != 3'b000 && k < 0) k = decode(row, column);
        end
        column = 3'b000;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_key   = '0;
        cmd_hold  = '0;
        column    = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total += 3;
            if (cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL rst_ready got %b want 0", cmd_ready);
            end
            if (row !== 3'b000) begin
                bad++;
                $display("FAIL rst_row got %b want 000", row);
            end
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_busy got %b want 0", busy);
            end
        end
        rst_n = 1'b1;
        #1;
        total += 2;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_rst_ready got %b want 1", cmd_ready);
        end
        if (press_active !== 1'b0) begin
            bad++;
            $display("FAIL post_rst_press got %b want 0", press_active);
        end
        column = 3'b000;
    endtask

    task automatic test_single_press;
        int dones;
        logic [2:0] exp;
        dones = 0;
        @(negedge clk);
        column = 3'b010;
        push(4, 5);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            column = 3'b010;
            #1;
            exp = (n <= 5) ? 3'b010 : 3'b000;
            total++;
            if (row !== exp) begin
                bad++;
                $display("FAIL single_row n=%0d got %b want %b", n, row, exp);
            end
            if (key_done === 1'b1) dones++;
            if (n == 6) begin
                total++;
                if (key_done !== 1'b1) begin
                    bad++;
                    $display("FAIL single_done_n6 got %b want 1", key_done);
                end
            end
            if (n == 3) begin
                column = 3'b001;
                #1;
                total++;
                if (row !== 3'b000) begin
                    bad++;
                    $display("FAIL single_col001 got %b want 000", row);
                end
                column = 3'b100;
                #1;
                total++;
                if (row !== 3'b000) begin
                    bad++;
                    $display("FAIL single_col100 got %b want 000", row);
                end
            end
            if (n == 13 || n == 14) begin
                total++;
                if (busy !== (n == 13)) begin
                    bad++;
                    $display("FAIL single_busy n=%0d got %b want %b", n, busy, (n == 13));
                end
            end
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL single_done_count got %0d want 1", dones);
        end
        column = 3'b000;
    endtask

    task automatic test_back_to_back;
        int  keys [5];
        int  starts [$];
        int  got [$];
        int  k;
        bit  prev;
        keys = '{0, 8, 2, 6, 3};
        prev = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 58; m++) begin
            if (m > 0) @(negedge clk);
            if (m <= 5 || m == 12 || m == 13) begin
                total++;
                if (cmd_ready !== (m != 5 && m != 12)) begin
                    bad++;
                    $display("FAIL queue_ready m=%0d got %b want %b",
                             m, cmd_ready, (m != 5 && m != 12));
                end
            end
            if (m == 55 || m == 56) begin
                total++;
                if (busy !== (m == 55)) begin
                    bad++;
                    $display("FAIL queue_busy m=%0d got %b want %b", m, busy, (m == 55));
                end
            end
            if (press_active && !prev) begin
                starts.push_back(m);
                scan_key(k);
                got.push_back(k);
            end
            prev = press_active;
            if (m < 5) begin
                cmd_valid = 1'b1;
                cmd_key   = 4'(keys[m]);
                cmd_hold  = 16'd2;
            end else begin
                cmd_valid = 1'b0;
            end
        end
        total++;
        if (starts.size() != 5) begin
            bad++;
            $display("FAIL queue_presses got %0d want 5", starts.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total += 2;
                if (starts[i] != 2 + 11 * i) begin
                    bad++;
                    $display("FAIL queue_start i=%0d got %0d want %0d", i, starts[i], 2 + 11 * i);
                end
                if (got[i] != keys[i]) begin
                    bad++;
                    $display("FAIL queue_key i=%0d got %0d want %0d", i, got[i], keys[i]);
                end
            end
        end
    endtask

    task automatic test_edges;
        int presses;
        presses = 0;
        @(negedge clk);
        push(9, 5);
        total++;
        if (cmd_err !== 1'b1) begin
            bad++;
            $display("FAIL err_pulse got %b want 1", cmd_err);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (press_active === 1'b1 || busy === 1'b1 || cmd_err === 1'b1) presses++;
        end
        total++;
        if (presses != 0) begin
            bad++;
            $display("FAIL err_activity got %0d want 0", presses);
        end
        push(8, 0);
        @(negedge clk);
        column = 3'b100;
        #1;
        total += 2;
        if (press_active !== 1'b1) begin
            bad++;
            $display("FAIL hold0_press got %b want 1", press_active);
        end
        if (row !== 3'b100) begin
            bad++;
            $display("FAIL hold0_row got %b want 100", row);
        end
        @(negedge clk);
        #1;
        total += 3;
        if (press_active !== 1'b0) begin
            bad++;
            $display("FAIL hold0_len got %b want 0", press_active);
        end
        if (key_done !== 1'b1) begin
            bad++;
            $display("FAIL hold0_done got %b want 1", key_done);
        end
        if (row !== 3'b000) begin
            bad++;
            $display("FAIL hold0_row_off got %b want 000", row);
        end
        column = 3'b000;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    endtask

    task automatic test_reset_mid_press;
        int events;
        events = 0;
        @(negedge clk);
        push(5, 20);
        push(1, 3);
        push(2, 3);
        repeat (5) @(negedge clk);
        column = 3'b100;
        #1;
        total++;
        if (row !== 3'b010) begin
            bad++;
            $display("FAIL midrst_pre_row got %b want 010", row);
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        total += 4;
        if (row !== 3'b000) begin
            bad++;
            $display("FAIL midrst_row got %b want 000", row);
        end
        if (press_active !== 1'b0) begin
            bad++;
            $display("FAIL midrst_press got %b want 0", press_active);
        end
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_busy got %b want 0", busy);
        end
        if (key_done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_done got %b want 0", key_done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (press_active === 1'b1 || key_done === 1'b1 || busy === 1'b1) events++;
        end
        total++;
        if (events != 0) begin
            bad++;
            $display("FAIL midrst_queue_dropped got %0d want 0", events);
        end
        column = 3'b000;
    endtask

    task automatic test_scanner_loop;
        int dec;
        int t;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            push(k, 40);
            dec = -1;
            for (int s = 0; s < 60; s++) begin
                @(negedge clk);
                column = 3'(1 << (s % 3));
                #1;
                if (row != 3'b000 && dec < 0) dec = decode(row, column);
            end
            column = 3'b000;
            t = 0;
            while (busy && t < 200) begin
                @(negedge clk);
                t++;
            end
            total += 2;
            if (dec != k) begin
                bad++;
                $display("FAIL scan_key got %0d want %0d", dec, k);
            end
            if (t >= 200) begin
                bad++;
                $display("FAIL scan_idle_timeout key=%0d got busy=1 want 0", k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_back_to_back();
        test_edges();
        test_reset_mid_press();
        test_scanner_loop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
